// File: rtl/step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : step_scheduler
//  Purpose  : Playback timing controller for the step sequencer. A Start
//             request with a nonzero BPM begins a run. The run produces
//             step_tick / step_idx / loop_count from a phase accumulator.
//             It ends after Loops passes, or at once on Stop.
//  Ports    : CLOCK_50   in   system clock
//             nReset     in   asynchronous active-low reset
//             Start      in   one-cycle request to begin playback
//             Stop       in   abort request (wins over Start and over ticks)
//             BPM        in   tempo in beats per minute, 0 = invalid
//             Loops      in   number of pattern passes, 0 = repeat forever
//             play_en    out  high while playback is running
//             step_tick  out  one-cycle pulse at the start of every step
//             step_idx   out  current step, 0..NUM_STEPS-1
//             loop_count out  completed passes in the current run
//             done       out  one-cycle pulse when playback ends
//  Options  : BPM_LIVE_EN - when defined, the step increment follows the live
//             BPM input every RUN cycle (BPM=0 freezes the current step).
//             When undefined, BPM is latched at Start.
//  Revision : 1.0 - initial release
// ============================================================================
module step_scheduler #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int NUM_STEPS      = 16,
    parameter int STEPS_PER_BEAT = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         nReset,
    input  logic                         Start,
    input  logic                         Stop,
    input  logic [9:0]                   BPM,
    input  logic [6:0]                   Loops,
    output logic                         play_en,
    output logic                         step_tick,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic [6:0]                   loop_count,
    output logic                         done
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    // One step lasts TH/INC cycles, where INC = BPM*STEPS_PER_BEAT.
    localparam logic [32:0]      TH        = 33'(64'(CLK_HZ) * 64'd60);
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t      state_q;
    logic [32:0] acc_q;
    logic [6:0]  loops_q;
    logic [32:0] inc_d;
    logic [32:0] acc_sum_d;
    logic        expire_d;
    logic [6:0]  loop_inc_d;

`ifdef BPM_LIVE_EN
    // Live tempo: a zero BPM adds nothing, so ACC holds and the step freezes.
    assign inc_d = 33'(BPM) * 33'(STEPS_PER_BEAT);
`else
    logic [9:0] bpm_q;
    assign inc_d = 33'(bpm_q) * 33'(STEPS_PER_BEAT);
`endif

    assign acc_sum_d  = acc_q + inc_d;
    assign expire_d   = (acc_sum_d >= TH);
    assign loop_inc_d = loop_count + 7'd1;

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            loops_q    <= '0;
`ifndef BPM_LIVE_EN
            bpm_q      <= '0;
`endif
            play_en    <= 1'b0;
            step_tick  <= 1'b0;
            step_idx   <= '0;
            loop_count <= '0;
            done       <= 1'b0;
        end else begin
            // Pulses default low; only the branches below raise them.
            step_tick <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start && !Stop && (BPM != 10'd0)) begin
`ifndef BPM_LIVE_EN
                        bpm_q      <= BPM;
`endif
                        loops_q    <= Loops;
                        acc_q      <= '0;
                        step_idx   <= '0;
                        loop_count <= '0;
                        play_en    <= 1'b1;
                        step_tick  <= 1'b1;   // step 0 starts on the first RUN cycle
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (Stop) begin
                        // Abort wins over any expiry in this cycle: no tick,
                        // step_idx and loop_count keep their current values.
                        play_en <= 1'b0;
                        done    <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        // Subtracting TH (not clearing) keeps the remainder,
                        // so the mean period is exactly TH/INC with no drift.
                        acc_q <= expire_d ? (acc_sum_d - TH) : acc_sum_d;
                        if (expire_d) begin
                            if (step_idx == LAST_STEP) begin
                                loop_count <= loop_inc_d;
                                if ((loops_q != 7'd0) && (loop_inc_d == loops_q)) begin
                                    play_en <= 1'b0;
                                    done    <= 1'b1;
                                    state_q <= S_FIN;
                                end else begin
                                    step_idx  <= '0;
                                    step_tick <= 1'b1;
                                end
                            end else begin
                                step_idx  <= step_idx + 1'b1;
                                step_tick <= 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_scheduler
//  Purpose  : Self-checking bench for step_scheduler (CLK_HZ=100, TH=6000).
//             The reference model uses closed-form step timing: after c RUN
//             cycles, floor(c*INC/TH) periods have expired.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_scheduler;

    localparam int     N   = 16;
    localparam int     SPB = 4;
    localparam longint TH  = 64'd6000;

    logic       clk;
    logic       nReset;
    logic       Start;
    logic       Stop;
    logic [9:0] BPM;
    logic [6:0] Loops;
    logic       play_en;
    logic       step_tick;
    logic [3:0] step_idx;
    logic [6:0] loop_count;
    logic       done;

    int checks = 0;
    int errors = 0;

    step_scheduler #(
        .CLK_HZ         (100),
        .NUM_STEPS      (N),
        .STEPS_PER_BEAT (SPB)
    ) dut (
        .CLOCK_50   (clk),
        .nReset     (nReset),
        .Start      (Start),
        .Stop       (Stop),
        .BPM        (BPM),
        .Loops      (Loops),
        .play_en    (play_en),
        .step_tick  (step_tick),
        .step_idx   (step_idx),
        .loop_count (loop_count),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs expected while IDLE (idx/loop values checked separately).
    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, ".play_en"}, 32'(play_en), 32'd0);
            chk({tag, ".tick"},    32'(step_tick), 32'd0);
            chk({tag, ".done"},    32'(done), 32'd0);
        end
    endtask

    // One full run. Offset c = 0 is the first RUN cycle.
    // stop_at: offset at which Stop is driven (seen by the DUT that cycle), -1 = none.
    // dup_at : offset at which a redundant Start is driven, -1 = none.
    task automatic run_check(input int bpm, input int loops, input int stop_at,
                             input int dup_at, input bit scramble, input string tag);
        longint inc, c_end, c_fin, e, e_prev, fin_idx, fin_loop;
        bit     stopped;
        inc   = longint'(bpm) * SPB;
        c_end = (loops == 0) ? 64'd1_000_000 : (longint'(N) * loops * TH + inc - 1) / inc;
        stopped = (stop_at >= 0) && (longint'(stop_at) + 1 <= c_end);
        c_fin = stopped ? longint'(stop_at) + 1 : c_end;
        fin_idx  = 0;
        fin_loop = 0;

        @(negedge clk);
        Start = 1'b1;
        BPM   = 10'(bpm);
        Loops = 7'(loops);
        for (longint c = 0; c <= c_fin + 1; c++) begin
            @(negedge clk);
            e      = (c * inc) / TH;
            e_prev = (c == 0) ? -1 : ((c - 1) * inc) / TH;
            if (c < c_fin) begin
                chk({tag, ".play_en"}, 32'(play_en), 32'd1);
                chk({tag, ".done"},    32'(done), 32'd0);
                chk({tag, ".tick"},    32'(step_tick), 32'(e != e_prev));
                chk({tag, ".idx"},     32'(step_idx), 32'(e % N));
                chk({tag, ".loop"},    32'(loop_count), 32'((e / N) % 128));
            end else if (c == c_fin) begin
                if (stopped) begin
                    fin_idx  = e_prev % N;
                    fin_loop = (e_prev / N) % 128;
                end else begin
                    fin_idx  = N - 1;
                    fin_loop = loops;
                end
                chk({tag, ".fin_play_en"}, 32'(play_en), 32'd0);
                chk({tag, ".fin_done"},    32'(done), 32'd1);
                chk({tag, ".fin_tick"},    32'(step_tick), 32'd0);
                chk({tag, ".fin_idx"},     32'(step_idx), 32'(fin_idx));
                chk({tag, ".fin_loop"},    32'(loop_count), 32'(fin_loop));
            end else begin
                chk({tag, ".post_play_en"}, 32'(play_en), 32'd0);
                chk({tag, ".post_done"},    32'(done), 32'd0);
                chk({tag, ".post_tick"},    32'(step_tick), 32'd0);
                chk({tag, ".post_idx"},     32'(step_idx), 32'(fin_idx));
                chk({tag, ".post_loop"},    32'(loop_count), 32'(fin_loop));
            end
            // Drive inputs for the DUT cycle at this offset.
            Start = (c == dup_at) && (c <= c_fin);
            Stop  = (c == stop_at) && (c < c_fin);
`ifndef BPM_LIVE_EN
            if (scramble && c < c_fin) BPM = 10'($urandom_range(0, 1023));
`endif
        end
        Start = 1'b0;
        Stop  = 1'b0;
        BPM   = 10'(bpm);
    endtask

    initial begin
        nReset = 1'b0;
        Start  = 1'b0;
        Stop   = 1'b0;
        BPM    = 10'd0;
        Loops  = 7'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.play_en", 32'(play_en), 32'd0);
        chk("rst.tick",    32'(step_tick), 32'd0);
        chk("rst.idx",     32'(step_idx), 32'd0);
        chk("rst.loop",    32'(loop_count), 32'd0);
        chk("rst.done",    32'(done), 32'd0);
        nReset = 1'b1;
        idle_cycles(2, "idle");

        // Exact 10-cycle steps, one pass
        run_check(150, 1, -1, -1, 1'b0, "bpm150");
        // Fractional period: 10/11-cycle mix, 7 intervals = 75 cycles
        run_check(140, 1, -1, -1, 1'b0, "bpm140");
        // Endless loop, Stop at the 20th tick (offset 190)
        run_check(150, 0, 190, -1, 1'b0, "forever_stop");

        // Start with BPM=0 is ignored
        @(negedge clk);
        Start = 1'b1;
        BPM   = 10'd0;
        Loops = 7'd1;
        @(negedge clk);
        Start = 1'b0;
        idle_cycles(3, "bpm0");
        // Start together with Stop in IDLE: Stop wins
        Start = 1'b1;
        Stop  = 1'b1;
        BPM   = 10'd200;
        @(negedge clk);
        Start = 1'b0;
        Stop  = 1'b0;
        idle_cycles(3, "start_stop");

        // Redundant Start mid-run leaves timing untouched
        run_check(150, 1, -1, 33, 1'b0, "dup_start");
        // Stop in the same cycle as an expiry (cycle 49 expires step 4)
        run_check(150, 1, 49, -1, 1'b0, "stop_on_expiry");
        // Stop on the cycle carrying the final expiry of a pass
        run_check(600, 1, 39, -1, 1'b0, "stop_on_last");

        // Asynchronous reset during step 7
        @(negedge clk);
        Start = 1'b1;
        BPM   = 10'd150;
        Loops = 7'd1;
        @(negedge clk);
        Start = 1'b0;
        repeat (70) @(negedge clk);
        chk("mid.idx",  32'(step_idx), 32'd7);
        chk("mid.tick", 32'(step_tick), 32'd1);
        #2 nReset = 1'b0;
        #1;
        chk("arst.play_en", 32'(play_en), 32'd0);
        chk("arst.tick",    32'(step_tick), 32'd0);
        chk("arst.idx",     32'(step_idx), 32'd0);
        chk("arst.loop",    32'(loop_count), 32'd0);
        chk("arst.done",    32'(done), 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        idle_cycles(3, "after_rst");
        run_check(150, 1, -1, -1, 1'b0, "restart");

        // Randomized runs, BPM input scrambled while running
        for (int r = 0; r < 6; r++) begin
            int b, l, s, d;
            b = int'($urandom_range(100, 1023));
            l = int'($urandom_range(1, 3));
            s = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(5, 300));
            d = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 60));
            run_check(b, l, s, d, 1'b1, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
